// File: rtl/axi_ctrl_pkg.sv
// Shared types and default widths for the AXI4 burst slave controller.
// Optional feature macro: AXI_RANGE_CHECK_EN (see axi_burst_addr_gen).
package axi_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_MEM_DEPTH  = 1024;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_ISSUE,
    RD_DATA
  } state_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: start word, LEN and beat counter -> memory word address.
// With AXI_RANGE_CHECK_EN, flags bursts whose last word lies past MEM_DEPTH-1.
module axi_burst_addr_gen
  import axi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int MEM_AW     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-3:0] word,
  input  logic [7:0]            len,
  input  logic                  inc,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  last,
  output logic                  range_err
);
  localparam int WW = ADDR_WIDTH - 2;

  logic [WW-1:0] start;
  logic [7:0]    len_q;
  logic [7:0]    beat;
  logic          err_q;
  logic          load_err;

`ifdef AXI_RANGE_CHECK_EN
  localparam int SW = ((WW > MEM_AW) ? WW : MEM_AW) + 9;
  logic [SW-1:0] end_word;
  assign end_word = SW'(word) + SW'(len);
  assign load_err = end_word > SW'(MEM_DEPTH - 1);
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      start <= '0;
      len_q <= '0;
      beat  <= '0;
      err_q <= 1'b0;
    end else if (load) begin
      start <= word;
      len_q <= len;
      beat  <= '0;
      err_q <= load_err;
    end else if (inc) begin
      beat <= beat + 8'd1;
    end
  end

  // Truncation to MEM_AW gives the modulo-depth wrap when range checking is off.
  assign mem_addr  = MEM_AW'(start) + MEM_AW'(beat);
  assign last      = (beat == len_q);
  assign range_err = err_q;
endmodule

// File: rtl/axi4_slave_ctrl.sv
// AXI4 INCR-burst slave bridging to a single-port synchronous memory, one burst in flight.
// Optional feature macro: AXI_RANGE_CHECK_EN (out-of-range bursts -> SLVERR, no memory access).
module axi4_slave_ctrl
  import axi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int MEM_AW     = $clog2(MEM_DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t                state;
  resp_t                 bresp_q;
  logic                  wr_err;
  logic                  ld_wr, ld_rd, wr_beat, rd_hs;
  logic                  last, rng;
  logic [MEM_AW-1:0]     gen_addr;
  logic [ADDR_WIDTH-3:0] ld_word;
  logic [7:0]            ld_len;
  logic                  unused_lsbs;

  assign unused_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  // Writes win a simultaneous AW/AR request.
  assign ld_wr   = (state == IDLE) & AWVALID;
  assign ld_rd   = (state == IDLE) & ~AWVALID & ARVALID;
  assign ld_word = AWVALID ? AWADDR[ADDR_WIDTH-1:2] : ARADDR[ADDR_WIDTH-1:2];
  assign ld_len  = AWVALID ? AWLEN : ARLEN;
  assign wr_beat = (state == WR_DATA) & WVALID;
  assign rd_hs   = (state == RD_DATA) & RREADY;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_AW    (MEM_AW)
  ) u_addr_gen (
    .clk      (ACLK),
    .rst      (ARESET),
    .load     (ld_wr | ld_rd),
    .word     (ld_word),
    .len      (ld_len),
    .inc      (wr_beat | rd_hs),
    .mem_addr (gen_addr),
    .last     (last),
    .range_err(rng)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      wr_err  <= 1'b0;
      bresp_q <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          wr_err <= 1'b0;
          if (AWVALID)      state <= WR_DATA;
          else if (ARVALID) state <= RD_ISSUE;
        end
        WR_DATA: if (WVALID) begin
          // Beat count comes from AWLEN; WLAST is only cross-checked.
          if (WLAST != last) wr_err <= 1'b1;
          if (last) begin
            state   <= WR_RESP;
            bresp_q <= (rng | wr_err | (WLAST != last)) ? SLVERR : OKAY;
          end
        end
        WR_RESP:  if (BREADY) state <= IDLE;
        RD_ISSUE: state <= RD_DATA;
        RD_DATA:  if (RREADY) state <= last ? IDLE : RD_ISSUE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign AWREADY   = (state == IDLE) & ~ARESET;
  assign ARREADY   = (state == IDLE) & ~AWVALID & ~ARESET;
  assign WREADY    = (state == WR_DATA);
  assign BVALID    = (state == WR_RESP);
  assign BRESP     = BVALID ? bresp_q : OKAY;
  assign RVALID    = (state == RD_DATA);
  assign RDATA     = (RVALID & ~rng) ? mem_rdata : '0;
  assign RRESP     = (RVALID & rng) ? SLVERR : OKAY;
  assign RLAST     = RVALID & last;

  // Memory holds mem_rdata while mem_en is low, so a stalled R beat stays stable.
  assign mem_en    = ~ARESET & ~rng & (wr_beat | (state == RD_ISSUE));
  assign mem_we    = ~ARESET & ~rng & wr_beat;
  assign mem_addr  = mem_en ? gen_addr : '0;
  assign mem_wdata = mem_we ? WDATA : '0;
endmodule

// File: tb/tb_axi4_slave_ctrl.sv
// Scoreboard bench for axi4_slave_ctrl; expectations follow AXI_RANGE_CHECK_EN when defined.
module tb_axi4_slave_ctrl;
  localparam int DEPTH = 1024;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [11:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic        AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 1, ARVALID = 0, RREADY = 1;
  logic [31:0] WDATA = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID, mem_en, mem_we;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  axi4_slave_ctrl dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  always @(posedge ACLK)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end

  typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] d; logic l; logic [1:0] r; } rd_t;
  wr_t        wr_q[$];
  rd_t        rd_q[$];
  logic [1:0] b_q[$];

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge ACLK) begin
    wr_t e; rd_t r; logic [1:0] b;
    if (mem_en && mem_we) begin
      if (wr_q.size() == 0) chk("wr_extra", 1, 0);
      else begin e = wr_q.pop_front(); chk("wr_addr", mem_addr, e.a); chk("wr_data", mem_wdata, e.d); end
    end
    if (BVALID && BREADY) begin
      if (b_q.size() == 0) chk("b_extra", 1, 0);
      else begin b = b_q.pop_front(); chk("bresp", BRESP, b); end
    end
    if (RVALID && RREADY) begin
      if (rd_q.size() == 0) chk("r_extra", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rdata", RDATA, r.d); chk("rlast", RLAST, r.l); chk("rresp", RRESP, r.r);
      end
    end
  end

  function automatic bit out_of_range(input logic [11:0] addr, input logic [7:0] len);
    int endw;
    endw = int'(addr[11:2]) + int'(len);
`ifdef AXI_RANGE_CHECK_EN
    return endw > DEPTH - 1;
`else
    return (endw < 0);
`endif
  endfunction

  task automatic do_write(input logic [11:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input int wlast_at);
    bit oob; int n; logic [9:0] wa;
    oob = out_of_range(addr, len);
    b_q.push_back((oob || wlast_at != int'(len)) ? 2'b10 : 2'b00);
    AWADDR = addr; AWLEN = len; AWVALID = 1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < 50) begin n++; @(negedge ACLK); end
    if (n >= 50) chk("aw_timeout", 0, 1);
    chk("ar_blocked", ARREADY, 0);
    @(posedge ACLK); #1 AWVALID = 0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = base + b; WLAST = (b == wlast_at); WVALID = 1;
      if (!oob) begin
        wa = addr[11:2] + 10'(b);
        wr_q.push_back('{wa, base + b});
        ref_mem[wa] = base + b;
      end
      @(negedge ACLK); chk("wready", WREADY, 1);
      @(posedge ACLK); #1;
    end
    WVALID = 0; WLAST = 0;
    @(negedge ACLK); chk("bvalid_lat", BVALID, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [7:0] len,
                         input int stall_beat, input int stall_n);
    bit oob; int n; logic [9:0] wa; logic [31:0] d0;
    oob = out_of_range(addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      wa = addr[11:2] + 10'(b);
      rd_q.push_back('{oob ? 32'h0 : ref_mem[wa], b == int'(len), oob ? 2'b10 : 2'b00});
    end
    ARADDR = addr; ARLEN = len; ARVALID = 1; RREADY = (stall_beat != 0);
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin n++; @(negedge ACLK); end
    if (n >= 50) chk("ar_timeout", 0, 1);
    @(posedge ACLK); #1 ARVALID = 0;
    @(negedge ACLK); chk("rd_issue_valid", RVALID, 0); chk("rd_issue_en", mem_en, oob ? 0 : 1);
    @(negedge ACLK); chk("rd_lat", RVALID, 1);
    for (int b = 0; b <= int'(len); b++) begin
      chk("rvalid", RVALID, 1);
      if (b == stall_beat) begin
        d0 = RDATA;
        repeat (stall_n) begin
          @(negedge ACLK);
          chk("stall_rdata", RDATA, d0); chk("stall_en", mem_en, 0); chk("stall_valid", RVALID, 1);
        end
        @(posedge ACLK); #1 RREADY = 1;
        @(negedge ACLK);
      end
      @(posedge ACLK); #1 RREADY = (b + 1 != stall_beat);
      if (b < int'(len)) begin
        @(negedge ACLK); chk("rd_gap", RVALID, 0);
        @(negedge ACLK);
      end
    end
    RREADY = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 0); chk("rst_arready", ARREADY, 0); chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_mem_en", mem_en, 0);   chk("rst_wready", WREADY, 0);
    @(posedge ACLK); #1 ARESET = 0;
    @(negedge ACLK); chk("idle_awready", AWREADY, 1); chk("idle_arready", ARREADY, 1);
    @(posedge ACLK); #1;

    do_write(12'h010, 8'd3, 32'hA0, 3);
    do_read (12'h010, 8'd3, -1, 0);

    // Simultaneous AW/AR: the write goes first, the pending AR is taken afterwards.
    ARADDR = 12'h020; ARLEN = 8'd1; ARVALID = 1;
    do_write(12'h020, 8'd1, 32'hB0, 1);
    do_read (12'h020, 8'd1, -1, 0);

    do_read (12'h010, 8'd3, 1, 5);

    do_write(12'h040, 8'd1, 32'hC0, -1);
    do_write(12'h050, 8'd2, 32'hD0, 0);
    do_read (12'h040, 8'd1, -1, 0);
    do_read (12'h050, 8'd2, -1, 0);

    do_write(12'hFF8, 8'd3, 32'hE0, 3);
    do_read (12'hFF8, 8'd3, -1, 0);

    // Reset after two of four beats: burst dropped, no B response, only two words changed.
    do_write(12'h100, 8'd3, 32'h10, 3);
    AWADDR = 12'h100; AWLEN = 8'd3; AWVALID = 1;
    @(negedge ACLK); chk("aw2_ready", AWREADY, 1);
    @(posedge ACLK); #1 AWVALID = 0;
    for (int b = 0; b < 2; b++) begin
      WDATA = 32'h20 + b; WVALID = 1; WLAST = 0;
      wr_q.push_back('{10'(64 + b), 32'h20 + b});
      ref_mem[64 + b] = 32'h20 + b;
      @(posedge ACLK); #1;
    end
    WDATA = 32'h22; ARESET = 1;
    @(negedge ACLK); chk("rst_mid_en", mem_en, 0);
    @(posedge ACLK); #1 WVALID = 0;
    @(negedge ACLK);
    chk("rstm_awready", AWREADY, 0); chk("rstm_wready", WREADY, 0); chk("rstm_bvalid", BVALID, 0);
    chk("rstm_bresp", BRESP, 0);     chk("rstm_rvalid", RVALID, 0); chk("rstm_rdata", RDATA, 0);
    chk("rstm_mem_en", mem_en, 0);   chk("rstm_mem_addr", mem_addr, 0);
    @(posedge ACLK); #1 ARESET = 0;
    repeat (3) begin @(negedge ACLK); chk("rstm_no_b", BVALID, 0); end
    chk("rstm_idle", AWREADY, 1);
    @(posedge ACLK); #1;
    do_read(12'h100, 8'd3, -1, 0);

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("b_q_empty",  b_q.size(),  0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
